ev21g1_issue_ctrl: RTL and testbench
====================================

# ev21g1_issue_ctrl

Hazard-aware microinstruction issue controller that sits directly in front of the ev21g1 datapath's `microinstruction` and `k` inputs. It buffers microinstructions from an upstream sequencer in a small FIFO and issues one word per clock. When a queued word reads a register that an in-flight word has not yet written back, it inserts NOP bubbles automatically, so software never has to pad hand-written flush NOPs. It also exposes idle status and issue/bubble counters for debug.

## Interface
- `FIFO_DEPTH`, 4: entries in the input queue (power of two, ≥2).
- `HAZARD_DEPTH`, 3: issued words tracked for write-back hazards; equals the datapath pipeline write latency.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high; sampled on rising edge of `clk`.
- `in_valid` in 1: upstream offers `in_uinstr`/`in_k`.
- `in_ready` out 1: queue can accept a word this cycle.
- `in_uinstr` in 30: microinstruction {aluc[29:26], sh[25:23], kmx[22], read[21], write[20], a[19:14], b[13:8], c[7:2], flip[1], print[0]}.
- `in_k` in 16: constant accompanying `in_uinstr`.
- `microinstruction` out 30: registered word driven to the datapath.
- `k` out 16: registered constant driven to the datapath.
- `idle` out 1: queue empty and all scoreboard entries are 6'h3F.
- `issue_count` out 16: non-NOP words issued; saturates at 16'hFFFF.
- `bubble_count` out 16: NOPs inserted for hazards; saturates at 16'hFFFF.

## Operation
- NOP word: aluc=0000, sh=000, kmx=0, read=0, write=0, a=0, b=0, c=6'h3F, flip=0, print=0; its `k` value is 0.
- Register 6'h3F is the "no write" destination. It never creates a hazard, as a destination or as a source.
- Enqueue: `in_valid && in_ready`. `in_ready = !full`. A dequeue in the same cycle does not free space for that cycle's enqueue.
- Source usage, decoded from the queue head:
  - uses_b when aluc ∈ {0001, 0011, 0100, 0101, 0110, 0111}.
  - uses_a when aluc ∈ {0100..0111} and kmx=0. When kmx=1, K replaces operand A.
  - aluc ∈ {0000, 1011, 1100} uses neither a nor b.
  - Any other aluc value, or write=1, conservatively uses both a and b.
- Scoreboard: shift register `sb[0..HAZARD_DEPTH-1]` holding destination c of the last issued words. `sb[0]` is the word currently on `microinstruction`.
- Hazard: the head is non-empty and, for some i, (uses_a and a==sb[i]) or (uses_b and b==sb[i]), with sb[i]≠6'h3F.
- Each cycle the controller does exactly one of the following:
  - Head present and no hazard: issue the head (pop it, drive word and `k`, shift c into sb[0]), and increment `issue_count`.
  - Head present and hazard: drive a NOP, shift 6'h3F into sb[0], and increment `bubble_count`.
  - Queue empty: drive a NOP and shift 6'h3F into sb[0]. No counter changes.
- There are no carry-flag hazards. A CY set/clear (1011/1100) may be followed immediately by add-with-carry (0101).
- Counters saturate and never wrap.

## Timing
- Reset values:
  - `microinstruction` = NOP and `k` = 0.
  - All sb entries = 6'h3F.
  - Queue is empty and `in_ready` = 1.
  - `idle` = 1 and both counters = 0.
- A reset asserted mid-operation discards all queued words and the scoreboard on that edge.
- A word enqueued at edge N can appear on `microinstruction` at edge N+1 at the earliest. There is no fall-through path.
- When word X is issued at edge t with c=Rx, a dependent word reading Rx issues no earlier than edge t+4, with exactly 3 NOPs between them when `HAZARD_DEPTH`=3.
- Independent words issue back-to-back at one per cycle.
- FIFO read and write pointers wrap modulo `FIFO_DEPTH`. Full and empty are distinguished by an extra pointer bit.
- `idle` is combinational from the registered state.

## Test plan
- Reset: assert `reset` for 2 cycles. Required: `microinstruction`=NOP, `k`=0, `idle`=1, `in_ready`=1, counters=0.
- Independent writes: enqueue R0=K(0), R1=K(1), R2=K(2) (aluc 0000, kmx=1). Required: issued on 3 consecutive edges, `bubble_count`=0, `issue_count`=3.
- RAW hazard: enqueue R0=K(5), then R10=R0 (aluc 0001, b=0, c=10). Required: exactly 3 NOPs between them, then `bubble_count`=3.
- kmx bypass: enqueue R23=K(FFFF)<<16, then R23=R23 OR K (aluc 0110, kmx=1, a=0, b=23). Required: 3 bubbles, caused by b only. Also enqueue R5=K with aluc 0110, kmx=1, a=5, b=7. Required: no hazard on a.
- Backpressure: hold `in_valid`=1 with 6 words that all depend on R1. Required: `in_ready` falls to 0 after 4 accepted, words issue in order, no word is lost or duplicated.
- Mid-run reset: assert `reset` with 3 words queued. Required: the next cycle shows a NOP output, `idle`=1, counters=0, and nothing further is issued.

Source files
------------

// File: rtl/ev21g1_issue_ctrl_if.sv
// Bundles the upstream handshake and the datapath-facing microinstruction bus.
interface ev21g1_issue_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [29:0] in_uinstr;
    logic [15:0] in_k;
    logic [29:0] microinstruction;
    logic [15:0] k;

    modport master (
        output in_valid, in_uinstr, in_k,
        input  in_ready, microinstruction, k
    );

    modport slave (
        input  in_valid, in_uinstr, in_k,
        output in_ready, microinstruction, k
    );
endinterface

// File: rtl/ev21g1_issue_ctrl.sv
// Hazard-aware issue controller: queues microinstructions and issues one per clock,
// inserting NOP bubbles while a source register is still awaiting write-back.
module ev21g1_issue_ctrl #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned HAZARD_DEPTH = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    ev21g1_issue_ctrl_if.slave   bus,
    output logic                 idle,
    output logic [15:0]          issue_count,
    output logic [15:0]          bubble_count
);
    localparam int unsigned PW     = $clog2(FIFO_DEPTH);
    localparam logic [5:0]  NO_REG = 6'h3F;
    localparam logic [29:0] NOP    = {4'b0000, 3'b000, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, NO_REG, 1'b0, 1'b0};

    logic [29:0] uq_q [FIFO_DEPTH];
    logic [15:0] kq_q [FIFO_DEPTH];

    logic [PW:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0] rd_ptr_q, rd_ptr_d;
    logic [29:0] mi_q, mi_d;
    logic [15:0] k_q, k_d;
    logic [5:0]  sb_q [HAZARD_DEPTH];
    logic [5:0]  sb_d [HAZARD_DEPTH];
    logic [15:0] issue_q, issue_d;
    logic [15:0] bubble_q, bubble_d;

    logic        empty, full, push, hazard, do_issue;
    logic [29:0] head_w;
    logic [15:0] head_k;
    logic [3:0]  aluc;
    logic [5:0]  src_a, src_b;
    logic        uses_a, uses_b;

    always_comb begin
        empty  = (wr_ptr_q == rd_ptr_q);
        full   = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
        push   = bus.in_valid && !full;
        head_w = uq_q[rd_ptr_q[PW-1:0]];
        head_k = kq_q[rd_ptr_q[PW-1:0]];
        aluc   = head_w[29:26];
        src_a  = head_w[19:14];
        src_b  = head_w[13:8];
    end

    // Operand decode; write=1 forces the conservative "both operands" case.
    always_comb begin
        uses_a = 1'b1;
        uses_b = 1'b1;
        if (!head_w[20]) begin
            case (aluc)
                4'b0000, 4'b1011, 4'b1100: begin
                    uses_a = 1'b0;
                    uses_b = 1'b0;
                end
                4'b0001, 4'b0011: begin
                    uses_a = 1'b0;
                    uses_b = 1'b1;
                end
                4'b0100, 4'b0101, 4'b0110, 4'b0111: begin
                    uses_a = !head_w[22];
                    uses_b = 1'b1;
                end
                default: begin
                    uses_a = 1'b1;
                    uses_b = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        hazard = 1'b0;
        for (int unsigned i = 0; i < HAZARD_DEPTH; i++) begin
            if (sb_q[i] != NO_REG) begin
                if ((uses_a && src_a == sb_q[i]) || (uses_b && src_b == sb_q[i]))
                    hazard = 1'b1;
            end
        end
        if (empty)
            hazard = 1'b0;
        do_issue = !empty && !hazard;
    end

    always_comb begin
        wr_ptr_d = push     ? wr_ptr_q + {{PW{1'b0}}, 1'b1} : wr_ptr_q;
        rd_ptr_d = do_issue ? rd_ptr_q + {{PW{1'b0}}, 1'b1} : rd_ptr_q;
        mi_d     = do_issue ? head_w : NOP;
        k_d      = do_issue ? head_k : '0;
        sb_d[0]  = do_issue ? head_w[7:2] : NO_REG;
        for (int unsigned i = 1; i < HAZARD_DEPTH; i++)
            sb_d[i] = sb_q[i-1];
        issue_d  = issue_q;
        bubble_d = bubble_q;
        if (do_issue && issue_q != '1)
            issue_d = issue_q + 16'd1;
        if (!empty && hazard && bubble_q != '1)
            bubble_d = bubble_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mi_q     <= NOP;
            k_q      <= '0;
            for (int unsigned i = 0; i < HAZARD_DEPTH; i++)
                sb_q[i] <= NO_REG;
            issue_q  <= '0;
            bubble_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mi_q     <= mi_d;
            k_q      <= k_d;
            for (int unsigned i = 0; i < HAZARD_DEPTH; i++)
                sb_q[i] <= sb_d[i];
            issue_q  <= issue_d;
            bubble_q <= bubble_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            uq_q[wr_ptr_q[PW-1:0]] <= bus.in_uinstr;
            kq_q[wr_ptr_q[PW-1:0]] <= bus.in_k;
        end
    end

    always_comb begin
        idle = empty;
        for (int unsigned i = 0; i < HAZARD_DEPTH; i++)
            if (sb_q[i] != NO_REG)
                idle = 1'b0;
    end

    assign bus.in_ready         = !full;
    assign bus.microinstruction = mi_q;
    assign bus.k                = k_q;
    assign issue_count          = issue_q;
    assign bubble_count         = bubble_q;
endmodule

// File: tb/tb_ev21g1_issue_ctrl.sv
// Bench for ev21g1_issue_ctrl: directed scenarios plus random traffic against a
// register-ready-time model of the issue rules.
module tb_ev21g1_issue_ctrl;
    localparam int FD = 4;
    localparam int HD = 3;
    localparam logic [29:0] NOP = 30'h0000_00FC;

    logic        clk;
    logic        rst;
    logic        idle;
    logic [15:0] issue_count, bubble_count;

    ev21g1_issue_ctrl_if bus ();

    ev21g1_issue_ctrl #(.FIFO_DEPTH(FD), .HAZARD_DEPTH(HD)) dut (
        .clk          (clk),
        .reset        (rst),
        .bus          (bus),
        .idle         (idle),
        .issue_count  (issue_count),
        .bubble_count (bubble_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Model: FIFO contents, and per register the first edge at which a reader may issue.
    logic [45:0] mq[$];
    int          ready_at[64];
    int          m_iss, m_bub;
    logic [29:0] m_mi;
    logic [15:0] m_k;
    int          cyc = 0;
    bit          last_acc;
    bit          pre_rdy;
    logic [29:0] hist_w[$];
    int          hist_t[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [29:0] mk(input int aluc, input int kmx, input int wr,
                                       input int a, input int b, input int c);
        logic [29:0] w;
        w = '0;
        w[29:26] = aluc[3:0];
        w[22]    = kmx[0];
        w[20]    = wr[0];
        w[19:14] = a[5:0];
        w[13:8]  = b[5:0];
        w[7:2]   = c[5:0];
        return w;
    endfunction

    function automatic bit m_blocked(input logic [29:0] w, input int e);
        bit ua, ub;
        int a, b;
        a = int'(w[19:14]);
        b = int'(w[13:8]);
        ua = 1; ub = 1;
        if (!w[20]) begin
            if (w[29:26] inside {4'd0, 4'd11, 4'd12}) begin ua = 0; ub = 0; end
            else if (w[29:26] inside {4'd1, 4'd3}) begin ua = 0; ub = 1; end
            else if (w[29:26] inside {[4'd4:4'd7]}) begin ua = !w[22]; ub = 1; end
        end
        return (ua && a != 63 && ready_at[a] > e) || (ub && b != 63 && ready_at[b] > e);
    endfunction

    task automatic tick();
        bit exp_rdy;
        bit m_idle;
        logic [45:0] h;
        #1;
        exp_rdy = (mq.size() < FD);
        pre_rdy = bus.in_ready;
        if (!rst) chk("in_ready", bus.in_ready, exp_rdy);
        cyc++;
        last_acc = 0;
        if (rst) begin
            mq.delete();
            foreach (ready_at[i]) ready_at[i] = 0;
            m_iss = 0; m_bub = 0; m_mi = NOP; m_k = '0;
        end else begin
            last_acc = bus.in_valid && exp_rdy;
            m_mi = NOP; m_k = '0;
            if (mq.size() > 0) begin
                h = mq[0];
                if (!m_blocked(h[45:16], cyc)) begin
                    void'(mq.pop_front());
                    m_mi = h[45:16];
                    m_k  = h[15:0];
                    if (h[23:18] != 6'h3F) ready_at[h[23:18]] = cyc + HD + 1;
                    if (m_iss < 65535) m_iss++;
                end else if (m_bub < 65535) m_bub++;
            end
            if (last_acc) mq.push_back({bus.in_uinstr, bus.in_k});
        end
        m_idle = (mq.size() == 0);
        foreach (ready_at[i]) if (ready_at[i] > cyc + 1) m_idle = 0;
        @(posedge clk);
        #1;
        chk("microinstruction", bus.microinstruction, m_mi);
        chk("k", bus.k, m_k);
        chk("idle", idle, m_idle);
        chk("issue_count", issue_count, m_iss);
        chk("bubble_count", bubble_count, m_bub);
        hist_w.push_back(bus.microinstruction);
        hist_t.push_back(cyc);
    endtask

    function automatic int t_of(input logic [29:0] w);
        foreach (hist_w[i]) if (hist_w[i] == w) return hist_t[i];
        return -1000;
    endfunction

    task automatic do_reset();
        rst = 1; bus.in_valid = 0;
        tick(); tick();
        rst = 0;
        hist_w.delete(); hist_t.delete();
    endtask

    task automatic send(input logic [29:0] w, input logic [15:0] kk);
        int n;
        bus.in_valid = 1; bus.in_uinstr = w; bus.in_k = kk;
        n = 0;
        do begin tick(); n++; end while (!last_acc && n < 20);
        if (!last_acc) chk("send_timeout", 0, 1);
        bus.in_valid = 0;
    endtask

    task automatic idle_ticks(input int n);
        bus.in_valid = 0;
        repeat (n) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [29:0] wa, wb, wc, wd;
        logic [29:0] deps[6];
        logic [29:0] pw;
        int idx, first_low;
        rst = 1; bus.in_valid = 0; bus.in_uinstr = '0; bus.in_k = '0;

        // reset state
        do_reset();
        chk("rst_mi", bus.microinstruction, NOP);
        chk("rst_k", bus.k, 0);
        chk("rst_idle", idle, 1);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_issue", issue_count, 0);
        chk("rst_bubble", bubble_count, 0);

        // independent writes issue back to back
        wa = mk(0, 1, 0, 0, 0, 0); wb = mk(0, 1, 0, 0, 0, 1); wc = mk(0, 1, 0, 0, 0, 2);
        send(wa, 16'd0); send(wb, 16'd1); send(wc, 16'd2);
        idle_ticks(6);
        chk("indep_gap01", t_of(wb) - t_of(wa), 1);
        chk("indep_gap12", t_of(wc) - t_of(wb), 1);
        chk("indep_bubble", bubble_count, 0);
        chk("indep_issue", issue_count, 3);

        // RAW on b: three NOPs between producer and consumer
        do_reset();
        wa = mk(0, 1, 0, 0, 0, 0); wb = mk(1, 0, 0, 0, 0, 10);
        send(wa, 16'd5); send(wb, 16'd0);
        idle_ticks(8);
        chk("raw_gap", t_of(wb) - t_of(wa), 4);
        chk("raw_bubble", bubble_count, 3);
        chk("raw_issue", issue_count, 2);

        // kmx=1: operand a is not a source
        do_reset();
        wa = mk(0, 1, 0, 0, 0, 23); wb = mk(6, 1, 0, 0, 23, 23);
        wc = mk(0, 1, 0, 0, 0, 5);  wd = mk(6, 1, 0, 5, 7, 5);
        send(wa, 16'hFFFF); send(wb, 16'h0); send(wc, 16'h1); send(wd, 16'h2);
        idle_ticks(10);
        chk("kmx_gap_b", t_of(wb) - t_of(wa), 4);
        chk("kmx_gap_a", t_of(wd) - t_of(wc), 1);
        chk("kmx_bubble", bubble_count, 3);

        // backpressure with six words reading R1
        do_reset();
        pw = mk(0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) deps[i] = mk(1, 0, 0, 0, 1, 10 + i);
        send(pw, 16'h7);
        idx = 0; first_low = -1;
        bus.in_valid = 1;
        for (int n = 0; n < 60 && idx < 6; n++) begin
            bus.in_uinstr = deps[idx]; bus.in_k = 16'(idx);
            tick();
            if (!pre_rdy && first_low < 0) first_low = idx;
            if (last_acc) idx++;
        end
        bus.in_valid = 0;
        chk("bp_all_accepted", idx, 6);
        chk("bp_ready_low_after", first_low, 4);
        idle_ticks(15);
        chk("bp_first_gap", t_of(deps[0]) - t_of(pw), 4);
        for (int i = 1; i < 6; i++) chk("bp_order", t_of(deps[i]) - t_of(deps[i-1]), 1);
        chk("bp_issue", issue_count, 7);
        chk("bp_bubble", bubble_count, 3);

        // reset with words still queued
        do_reset();
        send(pw, 16'h1); send(deps[0], 16'h0); send(deps[1], 16'h0); send(deps[2], 16'h0);
        rst = 1; tick(); rst = 0;
        chk("mrst_mi", bus.microinstruction, NOP);
        chk("mrst_idle", idle, 1);
        chk("mrst_issue", issue_count, 0);
        chk("mrst_bubble", bubble_count, 0);
        hist_w.delete(); hist_t.delete();
        idle_ticks(8);
        chk("mrst_no_d0", t_of(deps[0]), -1000);
        chk("mrst_no_d2", t_of(deps[2]), -1000);
        chk("mrst_issue_after", issue_count, 0);

        // random traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [29:0] w;
            int ra, rb, rc;
            ra = int'($urandom_range(0, 8)); if (ra == 8) ra = 63;
            rb = int'($urandom_range(0, 8)); if (rb == 8) rb = 63;
            rc = int'($urandom_range(0, 8)); if (rc == 8) rc = 63;
            w = 30'($urandom);
            w[20]    = ($urandom_range(0, 7) == 0);
            w[19:14] = ra[5:0];
            w[13:8]  = rb[5:0];
            w[7:2]   = rc[5:0];
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_uinstr = w;
            bus.in_k      = 16'($urandom);
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 0;
        idle_ticks(8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
